// File: rtl/mixer_pkg.sv
// Shared types and constants for the mixer time-share scheduler.
//   sched_state_t : scheduler FSM encoding
//   MRST_CYCLES   : how long the mixer reset is held after a watchdog trip
package mixer_pkg;

  typedef enum logic [2:0] {
    ARB    = 3'd0,
    ISSUE  = 3'd1,
    WAIT_I = 3'd2,
    WAIT_Q = 3'd3,
    GUARD  = 3'd4,
    MRST   = 3'd5
  } sched_state_t;

  localparam int unsigned MRST_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index of the most recent grant; search starts at ptr_i+1
//   gnt_o : one-hot grant
//   idx_o : index of the granted requester
//   any_o : at least one request present
module rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  logic [CH_W-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      k = CH_W'((32'(ptr_i) + i + 1) % N_CH);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mixer_scheduler.sv
// Time-shares one mixer between N_CH real-sample sources.
//   s_*   : per-channel sample inputs, round-robin arbitrated
//   mix_* : drive / observe the shared mixer (mix_rst_o is active-high)
//   m_*   : one I beat and one Q beat per sample, tagged with m_chan_o
//   err_o : sticky watchdog error, set when the mixer stalls
module mixer_scheduler
  import mixer_pkg::*;
#(
  parameter  int DW      = 16,
  parameter  int N_CH    = 4,
  parameter  int TIMEOUT = 64,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   s_data_i,
  input  logic [N_CH-1:0]      s_valid_i,
  output logic [N_CH-1:0]      s_ready_o,
  output logic [DW-1:0]        mix_data_o,
  output logic                 mix_valid_o,
  output logic                 mix_rst_o,
  input  logic [DW-1:0]        mix_data_i,
  input  logic                 mix_valid_i,
  input  logic                 mix_last_i,
  output logic                 mix_ready_o,
  output logic [DW-1:0]        m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  output logic [CH_W-1:0]      m_chan_o,
  input  logic                 m_ready_i,
  output logic                 err_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int MR_W = (MRST_CYCLES > 1) ? $clog2(MRST_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [MR_W-1:0] MR_LAST = MR_W'(MRST_CYCLES - 1);

  sched_state_t    state_q, state_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic [DW-1:0]   mix_data_q, mix_data_d;
  logic            mix_valid_q, mix_valid_d;
  logic            mix_rst_q, mix_rst_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [MR_W-1:0] mr_q, mr_d;

  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i (s_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (gnt[k]) sel_data = s_data_i[k*DW +: DW];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    chan_d      = chan_q;
    mix_data_d  = mix_data_q;
    mix_valid_d = 1'b0;
    err_d       = err_q;
    wd_d        = wd_q;
    mr_d        = mr_q;
    s_ready_o   = '0;
    m_valid_o   = 1'b0;

    case (state_q)
      ARB: begin
        // mix_rst_q is only high here in the cycle right after reset release,
        // which keeps s_ready_o low while rst_n is asserted.
        if (!mix_rst_q && gnt_any) begin
          s_ready_o   = gnt;
          mix_data_d  = sel_data;
          chan_d      = gnt_idx;
          rr_ptr_d    = gnt_idx;
          mix_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_I;
      end
      WAIT_I, WAIT_Q: begin
        m_valid_o = mix_valid_i & ((state_q == WAIT_Q) ? mix_last_i : ~mix_last_i);
        if (m_valid_o && m_ready_i) begin
          wd_d    = '0;
          state_d = (state_q == WAIT_I) ? WAIT_Q : GUARD;
        end else if (m_ready_i) begin
          if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            mr_d    = '0;
            state_d = MRST;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      GUARD: state_d = ARB;
      MRST: begin
        if (mr_q == MR_LAST) state_d = ARB;
        else                 mr_d    = mr_q + MR_W'(1);
      end
      default: state_d = ARB;
    endcase

    mix_rst_d = (state_d == MRST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= CH_W'(N_CH - 1);
      chan_q      <= '0;
      mix_data_q  <= '0;
      mix_valid_q <= 1'b0;
      mix_rst_q   <= 1'b1;
      err_q       <= 1'b0;
      wd_q        <= '0;
      mr_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      chan_q      <= chan_d;
      mix_data_q  <= mix_data_d;
      mix_valid_q <= mix_valid_d;
      mix_rst_q   <= mix_rst_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      mr_q        <= mr_d;
    end
  end

  assign mix_data_o  = mix_data_q;
  assign mix_valid_o = mix_valid_q;
  assign mix_rst_o   = mix_rst_q;
  assign mix_ready_o = m_valid_o & m_ready_i;
  assign m_data_o    = mix_data_i;
  assign m_last_o    = mix_last_i;
  assign m_chan_o    = chan_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mixer_scheduler.sv
module tb_mixer_scheduler;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NC*DW-1:0] s_data;
  logic [NC-1:0]  s_valid;
  logic [NC-1:0]  s_ready_o;
  logic [DW-1:0]  mix_data_o;
  logic           mix_valid_o, mix_rst_o, mix_ready_o;
  logic [DW-1:0]  mix_data_i;
  logic           mix_valid_i, mix_last_i;
  logic [DW-1:0]  m_data_o;
  logic           m_valid_o, m_last_o;
  logic [CW-1:0]  m_chan_o;
  logic           m_ready_i;
  logic           err_o;

  mixer_scheduler #(.DW(DW), .N_CH(NC), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
    .mix_data_o(mix_data_o), .mix_valid_o(mix_valid_o), .mix_rst_o(mix_rst_o),
    .mix_data_i(mix_data_i), .mix_valid_i(mix_valid_i), .mix_last_i(mix_last_i),
    .mix_ready_o(mix_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_chan_o(m_chan_o), .m_ready_i(m_ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Mixer model: I beat 3 cycles after accepting a sample, two duplicate
  // I beats after the I handshake, then Q, then one duplicate Q beat.
  typedef enum int {M_IDLE, M_DLY, M_I, M_DUPI, M_Q, M_DUPQ} mstate_t;
  mstate_t       ms = M_IDLE;
  int            dly = 0;
  logic [DW-1:0] smp = '0;
  bit            stall = 1'b0;

  always @(posedge clk) begin
    if (mix_rst_o) ms <= M_IDLE;
    else case (ms)
      M_IDLE: if (mix_valid_o && !stall) begin smp <= mix_data_o; dly <= 1; ms <= M_DLY; end
      M_DLY:  if (dly == 0) ms <= M_I; else dly <= dly - 1;
      M_I:    if (mix_ready_o) begin dly <= 1; ms <= M_DUPI; end
      M_DUPI: if (dly == 0) ms <= M_Q; else dly <= dly - 1;
      M_Q:    if (mix_ready_o) ms <= M_DUPQ;
      default: ms <= M_IDLE;
    endcase
  end

  assign mix_valid_i = (ms == M_I) || (ms == M_DUPI) || (ms == M_Q) || (ms == M_DUPQ);
  assign mix_last_i  = (ms == M_Q) || (ms == M_DUPQ);
  assign mix_data_i  = mix_last_i ? (smp ^ 16'hFF00) : (smp ^ 16'h00FF);

  // Monitor: cycle counter, grant log and accepted-beat log.
  typedef struct { int cyc; int ch; } grant_t;
  typedef struct { int cyc; int ch; bit last; logic [DW-1:0] data; } beat_t;
  grant_t gq[$];
  beat_t  bq[$];
  int     cyc = 0;

  function automatic int dec(input logic [NC-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NC; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && |s_ready_o) gq.push_back('{cyc, dec(s_ready_o)});
    if (rst_n && m_valid_o && m_ready_i)
      bq.push_back('{cyc, int'(m_chan_o), m_last_o, m_data_o});
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_grants(input int n, input int limit);
    int k = 0;
    while (gq.size() < n && k < limit) begin @(negedge clk); k++; end
    check("grant_wait", 32'(gq.size() >= n), 32'd1);
  endtask

  int g, r;

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 4'b0001; m_ready_i = 1'b1;
    s_data[0*DW +: DW] = 16'h1000;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready_o), 32'h0);
    check("rst_mix_valid", 32'(mix_valid_o), 32'h0);
    check("rst_mix_data", 32'(mix_data_o), 32'h0);
    check("rst_mix_rst", 32'(mix_rst_o), 32'h1);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_m_valid", 32'(m_valid_o), 32'h0);

    // Single channel
    rst_n = 1'b1; r = cyc;
    #1;
    check("rel_mix_rst_held", 32'(mix_rst_o), 32'h1);
    check("rel_s_ready_held", 32'(s_ready_o), 32'h0);
    wait_grants(1, 20);
    g = gq[0].cyc;
    s_valid = '0;
    check("single_grant_cyc", 32'(g), 32'(r + 1));
    check("single_grant_ch", 32'(gq[0].ch), 32'd0);
    to_cyc(g + 1);
    check("single_issue_valid", 32'(mix_valid_o), 32'h1);
    check("single_issue_data", 32'(mix_data_o), 32'h1000);
    check("single_mix_rst_low", 32'(mix_rst_o), 32'h0);
    to_cyc(g + 2);
    check("single_valid_once", 32'(mix_valid_o), 32'h0);
    to_cyc(g + 15);
    check("single_nbeats", 32'(bq.size()), 32'd2);
    check("single_i_cyc", 32'(bq[0].cyc), 32'(g + 4));
    check("single_i_last", 32'(bq[0].last), 32'h0);
    check("single_i_data", 32'(bq[0].data), 32'h10FF);
    check("single_i_ch", 32'(bq[0].ch), 32'd0);
    check("single_q_cyc", 32'(bq[1].cyc), 32'(g + 7));
    check("single_q_last", 32'(bq[1].last), 32'h1);
    check("single_q_data", 32'(bq[1].data), 32'hEF00);
    check("single_ngrants", 32'(gq.size()), 32'd1);

    // Backpressure during WAIT_I
    gq.delete(); bq.delete();
    s_data[3*DW +: DW] = 16'h3456; s_valid = 4'b1000;
    wait_grants(1, 20);
    g = gq[0].cyc;
    s_valid = '0;
    check("bp_grant_ch", 32'(gq[0].ch), 32'd3);
    to_cyc(g + 3);
    m_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      to_cyc(g + 4 + i);
      check("bp_mix_ready", 32'(mix_ready_o), 32'h0);
      check("bp_m_valid", 32'(m_valid_o), 32'h1);
      check("bp_m_data", 32'(m_data_o), 32'h34A9);
      check("bp_err", 32'(err_o), 32'h0);
    end
    m_ready_i = 1'b1;
    to_cyc(g + 35);
    check("bp_nbeats", 32'(bq.size()), 32'd2);
    check("bp_i_cyc", 32'(bq[0].cyc), 32'(g + 23));
    check("bp_q_cyc", 32'(bq[1].cyc), 32'(g + 26));
    check("bp_q_data", 32'(bq[1].data), 32'hCB56);
    check("bp_q_ch", 32'(bq[1].ch), 32'd3);
    check("bp_err_end", 32'(err_o), 32'h0);

    // Watchdog
    gq.delete(); bq.delete();
    stall = 1'b1;
    s_data[1*DW +: DW] = 16'h1111; s_data[2*DW +: DW] = 16'h2222;
    s_valid = 4'b0110;
    wait_grants(1, 20);
    g = gq[0].cyc;
    check("wd_grant_ch", 32'(gq[0].ch), 32'd1);
    to_cyc(g + 30);
    check("wd_s_ready_wait", 32'(s_ready_o), 32'h0);
    to_cyc(g + 65);
    check("wd_err_before", 32'(err_o), 32'h0);
    check("wd_rst_before", 32'(mix_rst_o), 32'h0);
    to_cyc(g + 66);
    check("wd_err_set", 32'(err_o), 32'h1);
    check("wd_rst_c1", 32'(mix_rst_o), 32'h1);
    check("wd_s_ready_mrst", 32'(s_ready_o), 32'h0);
    check("wd_m_valid_mrst", 32'(m_valid_o), 32'h0);
    stall = 1'b0;
    to_cyc(g + 67);
    check("wd_rst_c2", 32'(mix_rst_o), 32'h1);
    to_cyc(g + 68);
    check("wd_rst_done", 32'(mix_rst_o), 32'h0);
    check("wd_next_grant", 32'(s_ready_o), 32'h4);
    wait_grants(2, 20);
    s_valid = '0;
    check("wd_next_cyc", 32'(gq[1].cyc), 32'(g + 68));
    to_cyc(g + 80);
    check("wd_ch2_nbeats", 32'(bq.size()), 32'd2);
    check("wd_ch2_chan", 32'(bq[0].ch), 32'd2);
    check("wd_err_sticky", 32'(err_o), 32'h1);

    // Reset during WAIT_Q, then round robin from ch0
    gq.delete(); bq.delete();
    s_valid = 4'b0010;
    wait_grants(1, 20);
    g = gq[0].cyc;
    check("mid_grant_ch", 32'(gq[0].ch), 32'd1);
    s_valid = 4'b1111;
    to_cyc(g + 5);
    rst_n = 1'b0;
    #1;
    check("mid_s_ready", 32'(s_ready_o), 32'h0);
    check("mid_mix_valid", 32'(mix_valid_o), 32'h0);
    check("mid_mix_data", 32'(mix_data_o), 32'h0);
    check("mid_mix_rst", 32'(mix_rst_o), 32'h1);
    check("mid_err", 32'(err_o), 32'h0);
    check("mid_m_valid", 32'(m_valid_o), 32'h0);
    check("mid_m_chan", 32'(m_chan_o), 32'h0);
    repeat (2) @(negedge clk);
    gq.delete(); bq.delete();
    rst_n = 1'b1; r = cyc;
    wait_grants(8, 100);
    s_valid = '0;
    for (int i = 0; i < 8; i++) begin
      check("rr_ch", 32'(gq[i].ch), 32'(i % 4));
      check("rr_cyc", 32'(gq[i].cyc), 32'(r + 1 + 9 * i));
    end
    to_cyc(r + 76);
    check("rr_nbeats", 32'(bq.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("rr_beat_ch", 32'(bq[i].ch), 32'((i / 2) % 4));
      check("rr_beat_last", 32'(bq[i].last), 32'(i % 2));
    end

    // Sparse: only ch2
    gq.delete(); bq.delete();
    s_valid = 4'b0100;
    wait_grants(3, 60);
    s_valid = '0;
    for (int i = 0; i < 3; i++) check("sp_ch", 32'(gq[i].ch), 32'd2);
    check("sp_gap1", 32'(gq[1].cyc - gq[0].cyc), 32'd9);
    check("sp_gap2", 32'(gq[2].cyc - gq[1].cyc), 32'd9);
    to_cyc(cyc + 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
